// File: rtl/jtag_scan_master.sv
// JTAG scan master: derives TCK/TMS/TDI from clk, runs TAP reset, IR and DR scans
// requested over a valid/ready port and returns the captured TDO bits.
module jtag_scan_master #(
    parameter  int IR_LEN     = 5,
    parameter  int DR_MAX     = 40,
    parameter  int CLK_DIV    = 4,
    parameter  int RESET_TCKS = 8,
    parameter  int IDLE_TCKS  = 1,
    localparam int LW         = $clog2(DR_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [LW-1:0]     req_len,
    input  logic [DR_MAX-1:0] req_data,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DR_MAX-1:0] resp_data,
    output logic              busy,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    input  logic              jtag_tdo
);

    localparam int CMAX0 = (RESET_TCKS > DR_MAX) ? RESET_TCKS : DR_MAX;
    localparam int CMAX1 = (IR_LEN > CMAX0) ? IR_LEN : CMAX0;
    localparam int CMAX  = (IDLE_TCKS > CMAX1) ? IDLE_TCKS : CMAX1;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int DW    = $clog2(2 * CLK_DIV);

    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] FULL_LAST = DW'(2 * CLK_DIV - 1);

    localparam logic [1:0] K_RST = 2'b00;
    localparam logic [1:0] K_IR  = 2'b01;
    localparam logic [1:0] K_DR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RST_SEQ, S_HDR, S_SHIFT, S_UPD, S_RTI, S_DONE
    } state_t;

    state_t            state_q, state_d, nxt_state_s, ld_state_s;
    logic [CW-1:0]     bit_q, bit_d, nxt_bit_s, ld_bit_s, shift_last_s;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [1:0]        kind_q, kind_d;
    logic [LW-1:0]     n_q, n_d;
    logic [DR_MAX-1:0] tx_q, tx_d, rx_q, rx_d, mask_q, mask_d;
    logic              tap_known_q, tap_known_d;
    logic              err_q, err_d;
    logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic              req_ready_q, req_ready_d, busy_q, busy_d;
    logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [DR_MAX-1:0] resp_data_q, resp_data_d;
    logic              rst_done_s, load_s;

    function automatic logic tms_for(input state_t st, input logic [CW-1:0] b,
                                     input logic is_ir, input logic [CW-1:0] last);
        case (st)
            S_RST_SEQ: tms_for = (b < CW'(RESET_TCKS));
            S_HDR:     tms_for = is_ir ? (b < CW'(2)) : (b == CW'(0));
            S_SHIFT:   tms_for = (b == last);
            S_UPD:     tms_for = 1'b1;
            default:   tms_for = 1'b0;
        endcase
    endfunction

    // Successor of the TCK currently on the pins (state and bit index within it).
    always_comb begin
        shift_last_s = CW'(n_q) - CW'(1);
        nxt_state_s  = state_q;
        nxt_bit_s    = bit_q + CW'(1);
        rst_done_s   = 1'b0;
        case (state_q)
            S_RST_SEQ: begin
                if (bit_q == CW'(RESET_TCKS)) begin
                    rst_done_s  = 1'b1;
                    nxt_bit_s   = CW'(0);
                    nxt_state_s = (kind_q == K_RST) ? S_DONE : S_HDR;
                end else begin
                    nxt_state_s = S_RST_SEQ;
                end
            end
            S_HDR: begin
                if (bit_q == ((kind_q == K_IR) ? CW'(3) : CW'(2))) begin
                    nxt_bit_s   = CW'(0);
                    nxt_state_s = S_SHIFT;
                end else begin
                    nxt_state_s = S_HDR;
                end
            end
            S_SHIFT: begin
                if (bit_q == shift_last_s) begin
                    nxt_bit_s   = CW'(0);
                    nxt_state_s = S_UPD;
                end else begin
                    nxt_state_s = S_SHIFT;
                end
            end
            S_UPD: begin
                nxt_bit_s   = CW'(0);
                nxt_state_s = (IDLE_TCKS == 0) ? S_DONE : S_RTI;
            end
            S_RTI: begin
                if (bit_q == CW'(IDLE_TCKS) - CW'(1)) begin
                    nxt_bit_s   = CW'(0);
                    nxt_state_s = S_DONE;
                end else begin
                    nxt_state_s = S_RTI;
                end
            end
            default: nxt_state_s = state_q;
        endcase
    end

    // Request acceptance, TCK phase counting, pin sequencing and response generation.
    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        run_d        = run_q;
        kind_d       = kind_q;
        n_d          = n_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        mask_d       = mask_q;
        tap_known_d  = tap_known_q;
        err_d        = err_q;
        tck_d        = tck_q;
        tms_d        = tms_q;
        tdi_d        = tdi_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = resp_data_q;
        ld_state_s   = state_q;
        ld_bit_s     = bit_q;
        load_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tck_d = 1'b0;
                if (req_valid && req_ready_q) begin
                    kind_d = req_type;
                    n_d    = (req_type == K_IR) ? LW'(IR_LEN) : req_len;
                    tx_d   = req_data;
                    rx_d   = {DR_MAX{1'b0}};
                    mask_d = {{(DR_MAX-1){1'b0}}, 1'b1};
                    bit_d  = CW'(0);
                    cnt_d  = FULL_LAST;   // next edge opens the first low phase
                    run_d  = 1'b0;
                    err_d  = 1'b0;
                    case (req_type)
                        K_RST: state_d = S_RST_SEQ;
                        K_IR:  state_d = tap_known_q ? S_HDR : S_RST_SEQ;
                        K_DR: begin
                            if ((req_len == LW'(0)) || (req_len > LW'(DR_MAX))) begin
                                state_d = S_DONE;
                                err_d   = 1'b1;
                            end else begin
                                state_d = tap_known_q ? S_HDR : S_RST_SEQ;
                            end
                        end
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = {DR_MAX{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (cnt_q == HALF_LAST) begin
                    tck_d = 1'b1;
                    cnt_d = cnt_q + DW'(1);
                    if (state_q == S_SHIFT) begin
                        rx_d   = rx_q | (mask_q & {DR_MAX{jtag_tdo}});
                        mask_d = mask_q << 1;
                    end else begin
                        mask_d = mask_q;
                    end
                end else if (cnt_q == FULL_LAST) begin
                    tck_d = 1'b0;
                    cnt_d = DW'(0);
                    run_d = 1'b1;
                    if (!run_q) begin
                        load_s = 1'b1;
                    end else if (nxt_state_s == S_DONE) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = rx_q;
                    end else begin
                        state_d    = nxt_state_s;
                        bit_d      = nxt_bit_s;
                        ld_state_s = nxt_state_s;
                        ld_bit_s   = nxt_bit_s;
                        load_s     = 1'b1;
                    end
                    if (run_q && rst_done_s) begin
                        tap_known_d = 1'b1;
                    end else begin
                        tap_known_d = tap_known_q;
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
                if (load_s) begin
                    tms_d = tms_for(ld_state_s, ld_bit_s, (kind_q == K_IR), shift_last_s);
                    if (ld_state_s == S_SHIFT) begin
                        tdi_d = tx_q[0];
                        tx_d  = tx_q >> 1;
                    end else begin
                        tdi_d = 1'b0;
                    end
                end else begin
                    tms_d = tms_q;
                end
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers; reset parks the pins in TCK low / TMS high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            bit_q        <= {CW{1'b0}};
            cnt_q        <= {DW{1'b0}};
            run_q        <= 1'b0;
            kind_q       <= 2'b00;
            n_q          <= {LW{1'b0}};
            tx_q         <= {DR_MAX{1'b0}};
            rx_q         <= {DR_MAX{1'b0}};
            mask_q       <= {DR_MAX{1'b0}};
            tap_known_q  <= 1'b0;
            err_q        <= 1'b0;
            tck_q        <= 1'b0;
            tms_q        <= 1'b1;
            tdi_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= {DR_MAX{1'b0}};
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            kind_q       <= kind_d;
            n_q          <= n_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            mask_q       <= mask_d;
            tap_known_q  <= tap_known_d;
            err_q        <= err_d;
            tck_q        <= tck_d;
            tms_q        <= tms_d;
            tdi_q        <= tdi_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign jtag_tck   = tck_q;
    assign jtag_tms   = tms_q;
    assign jtag_tdi   = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a behavioural IEEE 1149.1 TAP on the pins.
module tb_jtag_scan_master;

    localparam int DR_MAX = 40;
    localparam int LW     = 6;
    localparam logic [39:0] DR_CAP = 40'hC3_5A5A_0F0F;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_type = 2'b00;
    logic [LW-1:0]     req_len = 6'd0;
    logic [DR_MAX-1:0] req_data = 40'h0;
    logic              resp_valid, resp_err, busy;
    logic [DR_MAX-1:0] resp_data;
    logic              jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

    jtag_scan_master #(
        .IR_LEN(5), .DR_MAX(DR_MAX), .CLK_DIV(4), .RESET_TCKS(8), .IDLE_TCKS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_len(req_len), .req_data(req_data),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
        .busy(busy),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
    );

    always #5 clk = ~clk;

    // ---------------- TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
        SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
    } tap_t;

    tap_t        tap = SHDR;
    logic [4:0]  ir_sr = 5'h0, ir_upd = 5'h0;
    logic [39:0] dr_sr = 40'h0, dr_upd = 40'h0;
    int          sh_cnt = 0, exit_idx = -1;
    logic        tdo_r = 1'b0;
    int          tck_cnt = 0, tms1_cnt = 0;

    assign jtag_tdo = tdo_r;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:     tap_next = tms ? TLR  : RTI;
            RTI:     tap_next = tms ? SDR  : RTI;
            SDR:     tap_next = tms ? SIR  : CDR;
            CDR:     tap_next = tms ? E1DR : SHDR;
            SHDR:    tap_next = tms ? E1DR : SHDR;
            E1DR:    tap_next = tms ? UDR  : PDR;
            PDR:     tap_next = tms ? E2DR : PDR;
            E2DR:    tap_next = tms ? UDR  : SHDR;
            UDR:     tap_next = tms ? SDR  : RTI;
            SIR:     tap_next = tms ? TLR  : CIR;
            CIR:     tap_next = tms ? E1IR : SHIR;
            SHIR:    tap_next = tms ? E1IR : SHIR;
            E1IR:    tap_next = tms ? UIR  : PIR;
            PIR:     tap_next = tms ? E2IR : PIR;
            E2IR:    tap_next = tms ? UIR  : SHIR;
            UIR:     tap_next = tms ? SDR  : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

    // TAP rising edge: capture, shift and state advance.
    always @(posedge jtag_tck) begin
        tck_cnt <= tck_cnt + 1;
        if (jtag_tms) tms1_cnt <= tms1_cnt + 1;
        case (tap)
            CIR:  begin ir_sr <= 5'b00001; sh_cnt <= 0; end
            CDR:  begin dr_sr <= DR_CAP;   sh_cnt <= 0; end
            SHIR: begin
                ir_sr  <= {jtag_tdi, ir_sr[4:1]};
                sh_cnt <= sh_cnt + 1;
                if (jtag_tms) exit_idx <= sh_cnt;
            end
            SHDR: begin
                dr_sr  <= {jtag_tdi, dr_sr[39:1]};
                sh_cnt <= sh_cnt + 1;
                if (jtag_tms) exit_idx <= sh_cnt;
            end
            default: ;
        endcase
        tap <= tap_next(tap, jtag_tms);
    end

    // TAP falling edge: update registers and drive TDO.
    always @(negedge jtag_tck) begin
        if (tap == UIR) ir_upd <= ir_sr;
        if (tap == UDR) dr_upd <= dr_sr;
        tdo_r <= (tap == SHIR) ? ir_sr[0] : ((tap == SHDR) ? dr_sr[0] : 1'b0);
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;
    int tck_start = 0, tms_start = 0;
    int lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [1:0] t, input logic [LW-1:0] l, input logic [39:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_type  = t;
        req_len   = l;
        req_data  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_type  = 2'b11;
        req_len   = 6'd63;
        req_data  = ~d;
        tck_start = tck_cnt;
        tms_start = tms1_cnt;
    endtask

    task automatic wait_resp(output int l);
        logic got;
        got = 1'b0;
        l   = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            l++;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("resp_seen", 64'(got), 64'(1));
    endtask

    task automatic after_resp(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 64'(resp_valid), 64'(0));
        check({tag, "_ready_back"}, 64'(req_ready), 64'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int quiet_resp;
        logic hit;

        #23;
        check("rst_tck", 64'(jtag_tck), 64'(0));
        check("rst_tms", 64'(jtag_tms), 64'(1));
        check("rst_tdi", 64'(jtag_tdi), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_err", 64'(resp_err), 64'(0));
        check("rst_resp_data", 64'(resp_data), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_rst", 64'(req_ready), 64'(1));

        // DR scan with TAP state unknown: 9 reset TCKs + 45 scan TCKs.
        send_req(2'b10, 6'd40, {6'h10, 32'h0, 2'b10});
        check("dr1_busy", 64'(busy), 64'(1));
        wait_resp(lat);
        check("dr1_latency", 64'(lat), 64'(433));
        check("dr1_tcks", 64'(tck_cnt - tck_start), 64'(54));
        check("dr1_tms1", 64'(tms1_cnt - tms_start), 64'(11));
        check("dr1_err", 64'(resp_err), 64'(0));
        check("dr1_resp", 64'(resp_data), 64'(DR_CAP));
        check("dr1_update", 64'(dr_upd), 64'(40'h40_0000_0002));
        check("dr1_shifts", 64'(sh_cnt), 64'(40));
        after_resp("dr1");

        // Second DR scan: no reset prefix.
        send_req(2'b10, 6'd40, 40'h12_3456_789A);
        wait_resp(lat);
        check("dr2_latency", 64'(lat), 64'(361));
        check("dr2_tcks", 64'(tck_cnt - tck_start), 64'(45));
        check("dr2_tms1", 64'(tms1_cnt - tms_start), 64'(3));
        check("dr2_resp", 64'(resp_data), 64'(DR_CAP));
        check("dr2_update", 64'(dr_upd), 64'(40'h12_3456_789A));
        check("dr2_exit_idx", 64'(exit_idx), 64'(39));

        // TAP reset request.
        send_req(2'b00, 6'd0, 40'h0);
        wait_resp(lat);
        check("trst_latency", 64'(lat), 64'(73));
        check("trst_tcks", 64'(tck_cnt - tck_start), 64'(9));
        check("trst_tms1", 64'(tms1_cnt - tms_start), 64'(8));
        check("trst_err", 64'(resp_err), 64'(0));
        check("trst_tap_rti", 64'(tap), 64'(RTI));
        after_resp("trst");

        // IR scan 0x11.
        send_req(2'b01, 6'd0, 40'h11);
        wait_resp(lat);
        check("ir_latency", 64'(lat), 64'(89));
        check("ir_tcks", 64'(tck_cnt - tck_start), 64'(11));
        check("ir_tms1", 64'(tms1_cnt - tms_start), 64'(4));
        check("ir_err", 64'(resp_err), 64'(0));
        check("ir_resp", 64'(resp_data), 64'(1));
        check("ir_update", 64'(ir_upd), 64'(5'h11));
        check("ir_exit_idx", 64'(exit_idx), 64'(4));
        check("ir_shifts", 64'(sh_cnt), 64'(5));
        check("ir_tap_rti", 64'(tap), 64'(RTI));

        // Rejected requests.
        send_req(2'b10, 6'd0, 40'hFF);
        wait_resp(lat);
        check("len0_latency", 64'(lat), 64'(1));
        check("len0_err", 64'(resp_err), 64'(1));
        check("len0_data", 64'(resp_data), 64'(0));
        check("len0_tcks", 64'(tck_cnt - tck_start), 64'(0));
        after_resp("len0");

        send_req(2'b10, 6'd41, 40'hFF);
        wait_resp(lat);
        check("len41_latency", 64'(lat), 64'(1));
        check("len41_err", 64'(resp_err), 64'(1));
        check("len41_data", 64'(resp_data), 64'(0));

        send_req(2'b11, 6'd8, 40'hFF);
        wait_resp(lat);
        check("type3_latency", 64'(lat), 64'(1));
        check("type3_err", 64'(resp_err), 64'(1));
        check("type3_data", 64'(resp_data), 64'(0));
        repeat (20) @(posedge clk);
        #1;
        check("err_no_tck", 64'(tck_cnt - tck_start), 64'(0));

        // Asynchronous reset while shifting DR bit 20.
        send_req(2'b10, 6'd40, 40'hAA_AAAA_AAAA);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (tap == SHDR && sh_cnt == 20) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_bit20", 64'(hit), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_tck", 64'(jtag_tck), 64'(0));
        check("mid_rst_tms", 64'(jtag_tms), 64'(1));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_ready", 64'(req_ready), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tck_start  = tck_cnt;
        quiet_resp = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) quiet_resp++;
        end
        check("mid_rst_no_resp", 64'(quiet_resp), 64'(0));
        check("mid_rst_no_tck", 64'(tck_cnt - tck_start), 64'(0));

        // IR scan after the abort must be prefixed by the reset sequence.
        send_req(2'b01, 6'd0, 40'h0A);
        wait_resp(lat);
        check("ir2_latency", 64'(lat), 64'(161));
        check("ir2_tcks", 64'(tck_cnt - tck_start), 64'(20));
        check("ir2_resp", 64'(resp_data), 64'(1));
        check("ir2_update", 64'(ir_upd), 64'(5'h0A));
        after_resp("ir2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
